// File: rtl/cs_pkg.sv
// Shared definitions for the compressed-sensing encoder: ternary coefficient
// encodings, FSM state encoding and a width helper safe for tiny parameters.
package cs_pkg;

    localparam logic [1:0] COEF_ZERO = 2'b00;
    localparam logic [1:0] COEF_POS  = 2'b01;
    localparam logic [1:0] COEF_NEG  = 2'b11;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2
    } cs_state_e;

    // Index width that never collapses to zero bits for counts of 1 or 2.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cs_coef_mem.sv
// Ternary Phi store: M_OUT x N_IN two-bit coefficients, cleared by reset,
// one write port and a LANES-wide read of the rows in the current group.
module cs_coef_mem
    import cs_pkg::*;
#(
    parameter int N_IN  = 96,
    parameter int M_OUT = 48,
    parameter int LANES = 4,
    localparam int ROW_W = clog2_safe(M_OUT),
    localparam int COL_W = clog2_safe(N_IN),
    localparam int GRP_W = clog2_safe(M_OUT / LANES)
) (
    input  logic                   sys_clk,
    input  logic                   sys_reset,
    input  logic                   wr_en,
    input  logic [ROW_W-1:0]       wr_row,
    input  logic [COL_W-1:0]       wr_col,
    input  logic [1:0]             wr_coef,
    input  logic [GRP_W-1:0]       rd_group,
    input  logic [COL_W-1:0]       rd_col,
    output logic [LANES-1:0][1:0]  rd_coef
);

    logic [1:0] mem [M_OUT][N_IN];

    // Coefficient storage: reset clears the whole matrix to zero.
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            for (int r = 0; r < M_OUT; r++) begin
                for (int c = 0; c < N_IN; c++) begin
                    mem[r][c] <= COEF_ZERO;
                end
            end
        end else if (wr_en) begin
            mem[wr_row][wr_col] <= wr_coef;
        end
    end

    // Lane l reads row group*LANES+l at the current column.
    always_comb begin
        rd_coef = '0;
        for (int l = 0; l < LANES; l++) begin
            rd_coef[l] = mem[ROW_W'(int'(rd_group) * LANES + l)][rd_col];
        end
    end

endmodule

// File: rtl/cs_encoder_param.sv
// Streaming compressed-sensing encoder y = Phi*x with a runtime-loaded ternary
// Phi; LANES rows are accumulated per cycle, no multipliers.
// Optional build macro CS_SAT_EN: saturating narrowing plus a sat_flag output;
// without it the measurement wraps to OUT_W bits.
//
// state  | meaning
// ACCEPT | waiting for the next sample; config writes allowed when col==0
// ACCUM  | applying the latched sample to one LANES-row group per cycle
// DRAIN  | presenting the M_OUT measurements on the output handshake
module cs_encoder_param
    import cs_pkg::*;
#(
    parameter int N_IN   = 96,
    parameter int M_OUT  = 48,
    parameter int LANES  = 4,
    parameter int DATA_W = 4,
    parameter int OUT_W  = 8,
    localparam int ACC_W = DATA_W + $clog2(N_IN) + 1,
    localparam int ROW_W = clog2_safe(M_OUT),
    localparam int COL_W = clog2_safe(N_IN)
) (
    input  logic                     sys_clk,
    input  logic                     sys_reset,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  out_data,
    output logic [ROW_W-1:0]         out_idx,
    output logic                     out_last,
    input  logic                     out_ready,
    input  logic                     cfg_we,
    input  logic [ROW_W-1:0]         cfg_row,
    input  logic [COL_W-1:0]         cfg_col,
    input  logic [1:0]               cfg_coef,
    output logic                     cfg_err,
`ifdef CS_SAT_EN
    output logic                     sat_flag,
`endif
    output logic                     busy
);

    localparam int N_GRP = M_OUT / LANES;
    localparam int GRP_W = clog2_safe(N_GRP);

    cs_state_e                state, state_nxt;
    logic [COL_W-1:0]         col;
    logic [GRP_W-1:0]         group;
    logic signed [DATA_W-1:0] sample;
    logic signed [ACC_W-1:0]  acc [M_OUT];
    logic signed [ACC_W-1:0]  sample_ext;
    logic [LANES-1:0][1:0]    lane_coef;
    logic                     ready_en;
    logic                     hs_in, hs_out, frame_done;
    logic                     last_grp, col_last, cfg_ok;

    assign sample_ext = {{(ACC_W-DATA_W){sample[DATA_W-1]}}, sample};
    assign last_grp   = (group == GRP_W'(N_GRP - 1));
    assign col_last   = (col == COL_W'(N_IN - 1));
    assign busy       = (col != '0) || (state != ACCEPT);
    assign cfg_ok     = cfg_we && !busy && (int'(cfg_row) < M_OUT) && (int'(cfg_col) < N_IN);

    cs_coef_mem #(
        .N_IN  (N_IN),
        .M_OUT (M_OUT),
        .LANES (LANES)
    ) u_coef_mem (
        .sys_clk   (sys_clk),
        .sys_reset (sys_reset),
        .wr_en     (cfg_ok),
        .wr_row    (cfg_row),
        .wr_col    (cfg_col),
        .wr_coef   (cfg_coef),
        .rd_group  (group),
        .rd_col    (col),
        .rd_coef   (lane_coef)
    );

    // State register.
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) state <= ACCEPT;
        else            state <= state_nxt;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_nxt  = state;
        in_ready   = (state == ACCEPT) && ready_en;
        out_valid  = (state == DRAIN);
        out_last   = out_valid && (out_idx == ROW_W'(M_OUT - 1));
        hs_in      = in_valid && in_ready;
        hs_out     = out_valid && out_ready;
        frame_done = hs_out && out_last;
        case (state)
            ACCEPT:  if (hs_in) state_nxt = ACCUM;
            ACCUM:   if (last_grp) state_nxt = col_last ? DRAIN : ACCEPT;
            DRAIN:   if (frame_done) state_nxt = ACCEPT;
            default: state_nxt = ACCEPT;
        endcase
    end

    // Holds in_ready low until the first clock after reset release.
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) ready_en <= 1'b0;
        else            ready_en <= 1'b1;
    end

    // Sample latch, row-group and column counters.
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            sample <= '0;
            group  <= '0;
            col    <= '0;
        end else begin
            case (state)
                ACCEPT: if (hs_in) begin
                    sample <= in_data;
                    group  <= '0;
                end
                ACCUM: begin
                    if (last_grp) begin
                        group <= '0;
                        col   <= col_last ? '0 : col + 1'b1;
                    end else begin
                        group <= group + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Accumulator bank: each entry of the active group adds, subtracts or holds.
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            for (int r = 0; r < M_OUT; r++) acc[r] <= '0;
        end else if (frame_done) begin
            for (int r = 0; r < M_OUT; r++) acc[r] <= '0;
        end else if (state == ACCUM) begin
            for (int r = 0; r < M_OUT; r++) begin
                if ((r / LANES) == int'(group)) begin
                    case (lane_coef[r % LANES])
                        COEF_POS: acc[r] <= acc[r] + sample_ext;
                        COEF_NEG: acc[r] <= acc[r] - sample_ext;
                        default:  acc[r] <= acc[r];
                    endcase
                end
            end
        end
    end

    // Output row index advances on each accepted measurement.
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset)    out_idx <= '0;
        else if (hs_out)   out_idx <= out_last ? '0 : out_idx + 1'b1;
    end

    // Rejected config writes: busy or out-of-range address.
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) cfg_err <= 1'b0;
        else            cfg_err <= cfg_we && !cfg_ok;
    end

`ifdef CS_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    logic signed [ACC_W-1:0] acc_sel;

    // Narrow the selected accumulator, clipping to the OUT_W signed range.
    always_comb begin
        acc_sel  = acc[out_idx];
        out_data = '0;
        sat_flag = 1'b0;
        if (out_valid) begin
            if (acc_sel > SAT_MAX) begin
                out_data = SAT_MAX[OUT_W-1:0];
                sat_flag = 1'b1;
            end else if (acc_sel < SAT_MIN) begin
                out_data = SAT_MIN[OUT_W-1:0];
                sat_flag = 1'b1;
            end else begin
                out_data = acc_sel[OUT_W-1:0];
            end
        end
    end
`else
    // Narrow the selected accumulator by truncation (two's complement wrap).
    always_comb begin
        out_data = '0;
        if (out_valid) out_data = OUT_W'(acc[out_idx]);
    end
`endif

endmodule

// File: tb/tb_cs_encoder_param.sv
// Bench for cs_encoder_param with N_IN=8, M_OUT=4, LANES=2, DATA_W=4, OUT_W=6.
// Builds with or without CS_SAT_EN.
module tb_cs_encoder_param;

    localparam int N_IN   = 8;
    localparam int M_OUT  = 4;
    localparam int LANES  = 2;
    localparam int DATA_W = 4;
    localparam int OUT_W  = 6;
    localparam int ROW_W  = 2;
    localparam int COL_W  = 3;
    localparam int SMAX   = 2 ** (OUT_W - 1) - 1;
    localparam int SMIN   = -(2 ** (OUT_W - 1));

    logic              sys_clk = 1'b0;
    logic              sys_reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic [OUT_W-1:0]  out_data;
    logic [ROW_W-1:0]  out_idx;
    logic              out_last;
    logic              out_ready = 1'b1;
    logic              cfg_we = 1'b0;
    logic [ROW_W-1:0]  cfg_row = '0;
    logic [COL_W-1:0]  cfg_col = '0;
    logic [1:0]        cfg_coef = '0;
    logic              cfg_err;
    logic              busy;
`ifdef CS_SAT_EN
    logic              sat_flag;
`endif

    cs_encoder_param #(
        .N_IN   (N_IN),
        .M_OUT  (M_OUT),
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_reset (sys_reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_ready (out_ready),
        .cfg_we    (cfg_we),
        .cfg_row   (cfg_row),
        .cfg_col   (cfg_col),
        .cfg_coef  (cfg_coef),
        .cfg_err   (cfg_err),
`ifdef CS_SAT_EN
        .sat_flag  (sat_flag),
`endif
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [ROW_W-1:0] idx;
        logic             last;
        logic             sat;
    } exp_t;

    exp_t sb[$];
    int   phi [M_OUT][N_IN];
    int   smp [N_IN];
    int   checks = 0;
    int   errors = 0;

    function automatic int sdata(input int v);
        logic signed [DATA_W-1:0] t;
        t = DATA_W'(v);
        return int'(t);
    endfunction

    function automatic int coef_val(input logic [1:0] k);
        if (k == 2'b01) return 1;
        if (k == 2'b11) return -1;
        return 0;
    endfunction

    task automatic push_frame();
        exp_t e;
        for (int r = 0; r < M_OUT; r++) begin
            int sum = 0;
            for (int c = 0; c < N_IN; c++) sum += phi[r][c] * sdata(smp[c]);
            e.idx  = ROW_W'(r);
            e.last = (r == M_OUT - 1);
            e.sat  = 1'b0;
`ifdef CS_SAT_EN
            if (sum > SMAX) begin
                e.data = OUT_W'(SMAX);
                e.sat  = 1'b1;
            end else if (sum < SMIN) begin
                e.data = OUT_W'(SMIN);
                e.sat  = 1'b1;
            end else begin
                e.data = OUT_W'(sum);
            end
`else
            e.data = OUT_W'(sum);
`endif
            sb.push_back(e);
        end
    endtask

    task automatic cfg_write(input int r, input int c, input logic [1:0] k,
                             input bit accept, input string nm);
        cfg_we   = 1'b1;
        cfg_row  = ROW_W'(r);
        cfg_col  = COL_W'(c);
        cfg_coef = k;
        @(negedge sys_clk);
        cfg_we = 1'b0;
        checks++;
        if (cfg_err !== !accept) begin
            errors++;
            $display("FAIL %s cfg_err got %b want %b", nm, cfg_err, !accept);
        end
        if (accept) phi[r][c] = coef_val(k);
    endtask

    task automatic send_sample(input int v, input string nm);
        int t = 0;
        in_valid = 1'b1;
        in_data  = DATA_W'(v);
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge sys_clk);
            t++;
        end
        checks++;
        if (t >= 50) begin
            errors++;
            $display("FAIL %s in_ready timeout got %b want 1", nm, in_ready);
        end
        @(negedge sys_clk);
        in_valid = 1'b0;
    endtask

    task automatic send_range(input int first, input string nm);
        for (int c = first; c < N_IN; c++) send_sample(smp[c], nm);
    endtask

    task automatic drain(input int stall_at, input int stall_n, input string nm);
        int   t = 0;
        int   got = 0;
        int   held = 0;
        exp_t e;
        out_ready = 1'b1;
        while (got < M_OUT && t < 200) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected output idx %0d data %0d", nm, out_idx, out_data);
                    got = M_OUT;
                end else begin
                    e = sb[0];
                    if (out_idx !== e.idx || out_data !== e.data || out_last !== e.last) begin
                        errors++;
                        $display("FAIL %s out got idx %0d data %0d last %b want idx %0d data %0d last %b",
                                 nm, out_idx, out_data, out_last, e.idx, e.data, e.last);
                    end
`ifdef CS_SAT_EN
                    checks++;
                    if (sat_flag !== e.sat) begin
                        errors++;
                        $display("FAIL %s sat_flag idx %0d got %b want %b", nm, out_idx, sat_flag, e.sat);
                    end
`endif
                    if (int'(out_idx) == stall_at && held < stall_n) begin
                        out_ready = 1'b0;
                        held++;
                    end else begin
                        out_ready = 1'b1;
                        void'(sb.pop_front());
                        got++;
                    end
                end
            end
            @(negedge sys_clk);
            t++;
        end
        out_ready = 1'b1;
        checks++;
        if (got < M_OUT) begin
            errors++;
            $display("FAIL %s drain timeout got %0d outputs want %0d", nm, got, M_OUT);
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s after last in_ready %b out_valid %b want 1 0", nm, in_ready, out_valid);
        end
        if (stall_n > 0) begin
            checks++;
            if (held != stall_n) begin
                errors++;
                $display("FAIL %s stall cycles got %0d want %0d", nm, held, stall_n);
            end
        end
    endtask

    task automatic check_reset_outputs(input string nm, input logic want_ready);
        checks++;
        if (in_ready !== want_ready || out_valid !== 1'b0 || out_data !== '0 || out_idx !== '0 ||
            out_last !== 1'b0 || cfg_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s got rdy %b vld %b data %0d idx %0d last %b err %b busy %b want rdy %b rest 0",
                     nm, in_ready, out_valid, out_data, out_idx, out_last, cfg_err, busy, want_ready);
        end
    endtask

    task automatic test_reset();
        for (int r = 0; r < M_OUT; r++)
            for (int c = 0; c < N_IN; c++) phi[r][c] = 0;
        repeat (2) @(negedge sys_clk);
        check_reset_outputs("reset_held", 1'b0);
        sys_reset = 1'b1;
        @(negedge sys_clk);
        check_reset_outputs("reset_release", 1'b1);
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < M_OUT; i++) cfg_write(i, i, 2'b01, 1'b1, "cfg_diag");
        for (int c = 0; c < N_IN; c++) smp[c] = c + 1;
        send_range(0, "single_in");
        push_frame();
        drain(-1, 0, "single_out");
    endtask

    task automatic test_subtract();
        for (int c = 0; c < N_IN; c++) cfg_write(0, c, 2'b11, 1'b1, "cfg_neg");
        cfg_write(1, 2, 2'b10, 1'b1, "cfg_reserved");
        for (int c = 0; c < N_IN; c++) smp[c] = -8;
        send_range(0, "sub_in");
        push_frame();
        drain(-1, 0, "sub_out");
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < N_IN; c++) smp[c] = int'($urandom_range(0, 15));
        send_range(0, "bp_in");
        push_frame();
        drain(2, 5, "bp_out");
        for (int c = 0; c < N_IN; c++) smp[c] = int'($urandom_range(0, 15));
        send_range(0, "bp_next_in");
        push_frame();
        drain(-1, 0, "bp_next_out");
    endtask

    task automatic test_cfg_reject();
        for (int c = 0; c < N_IN; c++) smp[c] = int'($urandom_range(1, 7));
        send_range(0, "rej_in");
        for (int c = 1; c < N_IN; c++) smp[c] = smp[c];
        smp[0] = smp[0];
        sb.delete();
        drain_frame_with_reject();
    endtask

    task automatic drain_frame_with_reject();
        // Second frame: the busy write lands after three samples.
        for (int c = 0; c < N_IN; c++) smp[c] = int'($urandom_range(1, 7));
        for (int c = 0; c < 3; c++) send_sample(smp[c], "rej2_in");
        cfg_write(0, 0, 2'b01, 1'b0, "cfg_busy_reject");
        checks++;
        @(negedge sys_clk);
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_pulse got %b want 0", cfg_err);
        end
        send_range(3, "rej2_in");
        push_frame();
        drain(-1, 0, "rej2_out");
        // Idle write together with the first sample of the next frame.
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_state in_ready %b busy %b want 1 0", in_ready, busy);
        end
        for (int c = 0; c < N_IN; c++) smp[c] = int'($urandom_range(1, 7));
        in_valid = 1'b1;
        in_data  = DATA_W'(smp[0]);
        cfg_write(0, 0, 2'b01, 1'b1, "cfg_with_sample");
        in_valid = 1'b0;
        send_range(1, "rej3_in");
        push_frame();
        drain(-1, 0, "rej3_out");
    endtask

    task automatic test_throughput();
        int acc_cyc[$];
        int cyc = 0;
        int n = 0;
        for (int c = 0; c < N_IN; c++) smp[c] = int'($urandom_range(0, 15));
        in_valid = 1'b1;
        in_data  = DATA_W'(smp[0]);
        while (n < N_IN && cyc < 200) begin
            if (in_ready === 1'b1) begin
                acc_cyc.push_back(cyc);
                n++;
            end
            @(negedge sys_clk);
            cyc++;
            if (n < N_IN) in_data = DATA_W'(smp[n]);
            else          in_valid = 1'b0;
        end
        checks++;
        if (n < N_IN) begin
            errors++;
            $display("FAIL tput_timeout got %0d samples want %0d", n, N_IN);
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != M_OUT / LANES + 1) begin
                errors++;
                $display("FAIL tput_interval sample %0d got %0d want %0d",
                         i, acc_cyc[i] - acc_cyc[i-1], M_OUT / LANES + 1);
            end
        end
        for (int k = 0; k < M_OUT / LANES; k++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL tput_early_valid accum cycle %0d got %b want 0", k, out_valid);
            end
            @(negedge sys_clk);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL tput_latency out_valid got %b want 1", out_valid);
        end
        push_frame();
        drain(-1, 0, "tput_out");
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < N_IN; c++) smp[c] = int'($urandom_range(1, 7));
        for (int c = 0; c < 5; c++) send_sample(smp[c], "mid_in");
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy got %b want 1", busy);
        end
        sys_reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset", 1'b0);
        @(negedge sys_clk);
        sys_reset = 1'b1;
        @(negedge sys_clk);
        check_reset_outputs("mid_release", 1'b1);
        for (int r = 0; r < M_OUT; r++)
            for (int c = 0; c < N_IN; c++) phi[r][c] = 0;
        for (int c = 0; c < N_IN; c++) smp[c] = int'($urandom_range(1, 7));
        send_range(0, "post_reset_in");
        push_frame();
        drain(-1, 0, "post_reset_out");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_subtract();
        test_backpressure();
        test_cfg_reject();
        test_throughput();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
